// File: rtl/nmi_apb_pkg.sv
// nmi_apb_pkg
// Shared types and defaults for the NMI-to-APB bridge:
//   state_e      - bridge FSM states (IDLE/SETUP/ACCESS/RESP)
//   err_cause_e  - error cause codes reported on err_cause_o
//   DEF_*        - default values for the bridge parameters
package nmi_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      DECERR  = 2'd1,
      SLVERR  = 2'd2,
      TIMEOUT = 2'd3
   } err_cause_e;

   localparam int          DEF_TIMEOUT_CYCLES = 256;
   localparam logic [31:0] DEF_ERR_RDATA      = 32'h0000_0000;

endpackage

// File: rtl/apb_addr_dec.sv
// apb_addr_dec
// Purely combinational base/mask address decoder.
// Ports:
//   addr_i  [31:0]              byte address to decode
//   base_i  [NUM_SLAVES*32-1:0] flattened base addresses, slave i in [32i+31:32i]
//   mask_i  [NUM_SLAVES*32-1:0] flattened compare masks
//   sel_o   [NUM_SLAVES-1:0]    one-hot select of the winning slave
//   hit_o                       at least one slave matched
//   idx_o   [IDX_W-1:0]         binary index of the winning slave
module apb_addr_dec #(
   parameter int NUM_SLAVES = 8,
   parameter int IDX_W      = 3
) (
   input  logic [31:0]              addr_i,
   input  logic [NUM_SLAVES*32-1:0] base_i,
   input  logic [NUM_SLAVES*32-1:0] mask_i,
   output logic [NUM_SLAVES-1:0]    sel_o,
   output logic                     hit_o,
   output logic [IDX_W-1:0]         idx_o
);

   // Scan from the highest index down so the lowest matching slave is
   // the last assignment and therefore wins on overlapping windows.
   always_comb begin
      sel_o = '0;
      hit_o = 1'b0;
      idx_o = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((addr_i & mask_i[32*i +: 32]) == base_i[32*i +: 32]) begin
            sel_o    = '0;
            sel_o[i] = 1'b1;
            hit_o    = 1'b1;
            idx_o    = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/nmi_apb_bridge.sv
// nmi_apb_bridge
// Bridge from the native valid/ready memory interface to an N-slave APB4
// bus, with base/mask decoding, a pready timeout, error responses and a
// sticky first-error capture register. All outputs are registered.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   mem_valid_i/addr_i/wdata_i/wstrb_i request (wstrb == 0 is a read)
//   mem_rdata_o/ready_o/err_o         one-cycle completion with data/error
//   apb_*_o                           APB4 master outputs (psel one-hot)
//   apb_pready_i/pslverr_i/prdata_i   per-slave APB responses (flattened)
//   err_valid_o/addr_o/cause_o        sticky capture of the first error
//   err_clr_i                         clears err_valid_o
module nmi_apb_bridge
   import nmi_apb_pkg::*;
#(
   parameter int                       NUM_SLAVES     = 8,
   parameter logic [NUM_SLAVES*32-1:0] SLV_BASE       = '0,
   parameter logic [NUM_SLAVES*32-1:0] SLV_MASK       = '0,
   parameter int                       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter logic [31:0]              ERR_RDATA      = DEF_ERR_RDATA
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     mem_valid_i,
   input  logic [31:0]              mem_addr_i,
   input  logic [31:0]              mem_wdata_i,
   input  logic [3:0]               mem_wstrb_i,
   output logic [31:0]              mem_rdata_o,
   output logic                     mem_ready_o,
   output logic                     mem_err_o,
   output logic [31:0]              apb_paddr_o,
   output logic [2:0]               apb_pprot_o,
   output logic [NUM_SLAVES-1:0]    apb_psel_o,
   output logic                     apb_penable_o,
   output logic                     apb_pwrite_o,
   output logic [31:0]              apb_pwdata_o,
   output logic [3:0]               apb_pstrb_o,
   input  logic [NUM_SLAVES-1:0]    apb_pready_i,
   input  logic [NUM_SLAVES-1:0]    apb_pslverr_i,
   input  logic [NUM_SLAVES*32-1:0] apb_prdata_i,
   output logic                     err_valid_o,
   output logic [31:0]              err_addr_o,
   output logic [1:0]               err_cause_o,
   input  logic                     err_clr_i
);

   localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   state_e                  state_q, state_d;
   logic [31:0]             addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              wstrb_q, wstrb_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_SLAVES-1:0]   psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic                    merr_q, merr_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    err_valid_q, err_valid_d;
   logic [31:0]             err_addr_q, err_addr_d;
   err_cause_e              err_cause_q, err_cause_d;

   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_hit;
   logic [IDX_W-1:0]        dec_idx;

   logic                    new_err;
   err_cause_e              new_cause;
   logic [31:0]             new_addr;

   logic                    pready_sel;
   logic                    pslverr_sel;
   logic [31:0]             prdata_sel;

   apb_addr_dec #(
      .NUM_SLAVES (NUM_SLAVES),
      .IDX_W      (IDX_W)
   ) u_dec (
      .addr_i (mem_addr_i),
      .base_i (SLV_BASE),
      .mask_i (SLV_MASK),
      .sel_o  (dec_sel),
      .hit_o  (dec_hit),
      .idx_o  (dec_idx)
   );

   // Response mux keyed by the index registered at request acceptance.
   assign pready_sel  = apb_pready_i[idx_q];
   assign pslverr_sel = apb_pslverr_i[idx_q];
   assign prdata_sel  = apb_prdata_i[32*int'(idx_q) +: 32];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      idx_d     = idx_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      cnt_d     = cnt_q;
      ready_d   = 1'b0;
      merr_d    = merr_q;
      rdata_d   = rdata_q;
      new_err   = 1'b0;
      new_cause = NONE;
      new_addr  = addr_q;

      case (state_q)
         IDLE: begin
            if (mem_valid_i) begin
               addr_d  = mem_addr_i;
               wdata_d = mem_wdata_i;
               wstrb_d = mem_wstrb_i;
               if (dec_hit) begin
                  idx_d   = dec_idx;
                  psel_d  = dec_sel;
                  state_d = SETUP;
               end else begin
                  state_d   = RESP;
                  ready_d   = 1'b1;
                  merr_d    = 1'b1;
                  rdata_d   = ERR_RDATA;
                  new_err   = 1'b1;
                  new_cause = DECERR;
                  new_addr  = mem_addr_i;
               end
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            // pready is checked first so it wins over a coincident timeout.
            if (pready_sel) begin
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = RESP;
               ready_d   = 1'b1;
               merr_d    = pslverr_sel;
               rdata_d   = (pslverr_sel || (|wstrb_q)) ? ERR_RDATA : prdata_sel;
               new_err   = pslverr_sel;
               new_cause = SLVERR;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = RESP;
               ready_d   = 1'b1;
               merr_d    = 1'b1;
               rdata_d   = ERR_RDATA;
               new_err   = 1'b1;
               new_cause = TIMEOUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            merr_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A clear coinciding with a new error still lets the new error in.
   always_comb begin
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      err_cause_d = err_cause_q;
      if (err_clr_i) begin
         err_valid_d = 1'b0;
      end
      if (new_err && (!err_valid_q || err_clr_i)) begin
         err_valid_d = 1'b1;
         err_addr_d  = new_addr;
         err_cause_d = new_cause;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         idx_q       <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         merr_q      <= 1'b0;
         rdata_q     <= '0;
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
         err_cause_q <= NONE;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         idx_q       <= idx_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         merr_q      <= merr_d;
         rdata_q     <= rdata_d;
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
         err_cause_q <= err_cause_d;
      end
   end

   assign mem_rdata_o   = rdata_q;
   assign mem_ready_o   = ready_q;
   assign mem_err_o     = merr_q;
   assign apb_paddr_o   = addr_q;
   assign apb_pprot_o   = 3'b000;
   assign apb_psel_o    = psel_q;
   assign apb_penable_o = penable_q;
   assign apb_pwrite_o  = |wstrb_q;
   assign apb_pwdata_o  = wdata_q;
   assign apb_pstrb_o   = wstrb_q;
   assign err_valid_o   = err_valid_q;
   assign err_addr_o    = err_addr_q;
   assign err_cause_o   = err_cause_q;

endmodule

// File: tb/tb_nmi_apb_bridge.sv
// tb_nmi_apb_bridge
// Directed bench for nmi_apb_bridge with three slaves:
//   slave 0: 0x0300_2000 / 0xFFFF_F000
//   slave 1: 0x0300_1000 / 0xFFFF_F000
//   slave 2: 0x0300_0000 / 0xFFFF_C000 (overlaps slave 0 and slave 1)
// Slave i returns prdata 0xA5A5_000i.
module tb_nmi_apb_bridge;

   localparam int          NS   = 3;
   localparam logic [31:0] ERRD = 32'hEEEE_0BAD;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_valid;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_rdata;
   logic              mem_ready;
   logic              mem_err;
   logic [31:0]       paddr;
   logic [2:0]        pprot;
   logic [NS-1:0]     psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       pwdata;
   logic [3:0]        pstrb;
   logic [NS-1:0]     pready;
   logic [NS-1:0]     pslverr;
   logic [NS*32-1:0]  prdata;
   logic              err_valid;
   logic [31:0]       err_addr;
   logic [1:0]        err_cause;
   logic              err_clr;

   int errors = 0;
   int checks = 0;

   assign prdata = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

   always #5 clk = ~clk;

   nmi_apb_bridge #(
      .NUM_SLAVES     (NS),
      .SLV_BASE       ({32'h0300_0000, 32'h0300_1000, 32'h0300_2000}),
      .SLV_MASK       ({32'hFFFF_C000, 32'hFFFF_F000, 32'hFFFF_F000}),
      .TIMEOUT_CYCLES (8),
      .ERR_RDATA      (ERRD)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .mem_valid_i   (mem_valid),
      .mem_addr_i    (mem_addr),
      .mem_wdata_i   (mem_wdata),
      .mem_wstrb_i   (mem_wstrb),
      .mem_rdata_o   (mem_rdata),
      .mem_ready_o   (mem_ready),
      .mem_err_o     (mem_err),
      .apb_paddr_o   (paddr),
      .apb_pprot_o   (pprot),
      .apb_psel_o    (psel),
      .apb_penable_o (penable),
      .apb_pwrite_o  (pwrite),
      .apb_pwdata_o  (pwdata),
      .apb_pstrb_o   (pstrb),
      .apb_pready_i  (pready),
      .apb_pslverr_i (pslverr),
      .apb_prdata_i  (prdata),
      .err_valid_o   (err_valid),
      .err_addr_o    (err_addr),
      .err_cause_o   (err_cause),
      .err_clr_i     (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = d;
      mem_wstrb = s;
   endtask

   initial begin
      rst       = 1'b1;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      pready    = '1;
      pslverr   = '0;
      err_clr   = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_ready",     32'(mem_ready), 32'h0);
      chk("rst_psel",      32'(psel),      32'h0);
      chk("rst_penable",   32'(penable),   32'h0);
      chk("rst_err_valid", 32'(err_valid), 32'h0);
      chk("rst_err_addr",  err_addr,       32'h0);
      chk("rst_err_cause", 32'(err_cause), 32'h0);
      chk("rst_rdata",     mem_rdata,      32'h0);
      chk("rst_paddr",     paddr,          32'h0);
      chk("pprot",         32'(pprot),     32'h0);

      // Zero-wait read of slave 1
      rst = 1'b0;
      req(32'h0300_1004, 32'h0, 4'b0000);
      tick();
      chk("zw_c1_psel",    32'(psel),    32'h2);
      chk("zw_c1_penable", 32'(penable), 32'h0);
      chk("zw_c1_ready",   32'(mem_ready), 32'h0);
      chk("zw_c1_paddr",   paddr,        32'h0300_1004);
      chk("zw_c1_pwrite",  32'(pwrite),  32'h0);
      tick();
      chk("zw_c2_psel",    32'(psel),    32'h2);
      chk("zw_c2_penable", 32'(penable), 32'h1);
      chk("zw_c2_ready",   32'(mem_ready), 32'h0);
      tick();
      chk("zw_c3_ready",   32'(mem_ready), 32'h1);
      chk("zw_c3_err",     32'(mem_err),   32'h0);
      chk("zw_c3_rdata",   mem_rdata,      32'hA5A5_0001);
      chk("zw_c3_psel",    32'(psel),      32'h0);
      tick();
      mem_valid = 1'b0;
      chk("zw_c4_ready",   32'(mem_ready), 32'h0);
      tick();

      // Wait-state write to slave 0, four stall cycles
      pready[0] = 1'b0;
      req(32'h0300_2010, 32'h1234_5678, 4'b0011);
      for (int c = 1; c <= 6; c++) begin
         tick();
         pready[0] = (c == 6);
         chk("ws_psel",    32'(psel),      32'h1);
         chk("ws_penable", 32'(penable),   (c >= 2) ? 32'h1 : 32'h0);
         chk("ws_pwrite",  32'(pwrite),    32'h1);
         chk("ws_pstrb",   32'(pstrb),     32'h3);
         chk("ws_pwdata",  pwdata,         32'h1234_5678);
         chk("ws_ready",   32'(mem_ready), 32'h0);
      end
      tick();
      chk("ws_c7_ready", 32'(mem_ready), 32'h1);
      chk("ws_c7_err",   32'(mem_err),   32'h0);
      chk("ws_c7_rdata", mem_rdata,      ERRD);
      chk("ws_c7_psel",  32'(psel),      32'h0);
      tick();
      mem_valid = 1'b0;
      pready    = '1;
      tick();

      // Decode miss
      req(32'hDEAD_0000, 32'h0, 4'b0000);
      tick();
      chk("dm_ready",     32'(mem_ready), 32'h1);
      chk("dm_err",       32'(mem_err),   32'h1);
      chk("dm_rdata",     mem_rdata,      ERRD);
      chk("dm_psel",      32'(psel),      32'h0);
      chk("dm_err_valid", 32'(err_valid), 32'h1);
      chk("dm_err_addr",  err_addr,       32'hDEAD_0000);
      chk("dm_err_cause", 32'(err_cause), 32'h1);
      tick();
      mem_valid = 1'b0;
      chk("dm_c2_psel",   32'(psel),      32'h0);
      chk("dm_c2_ready",  32'(mem_ready), 32'h0);

      // Clear the capture
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_err_valid", 32'(err_valid), 32'h0);

      // Timeout on slave 2 (never ready)
      pready[2] = 1'b0;
      req(32'h0300_3000, 32'h0, 4'b0000);
      for (int c = 1; c <= 9; c++) begin
         tick();
         chk("to_ready", 32'(mem_ready), 32'h0);
         chk("to_psel",  32'(psel),      32'h4);
      end
      chk("to_c9_penable", 32'(penable), 32'h1);
      tick();
      chk("to_c10_ready",  32'(mem_ready), 32'h1);
      chk("to_c10_err",    32'(mem_err),   32'h1);
      chk("to_c10_rdata",  mem_rdata,      ERRD);
      chk("to_c10_psel",   32'(psel),      32'h0);
      chk("to_c10_pen",    32'(penable),   32'h0);
      chk("to_err_valid",  32'(err_valid), 32'h1);
      chk("to_err_cause",  32'(err_cause), 32'h3);
      chk("to_err_addr",   err_addr,       32'h0300_3000);
      tick();
      mem_valid = 1'b0;
      pready    = '1;
      tick();

      // pslverr on slave 1: error response, capture unchanged
      pslverr[1] = 1'b1;
      req(32'h0300_1008, 32'h0, 4'b0000);
      tick();
      tick();
      tick();
      chk("se_ready",     32'(mem_ready), 32'h1);
      chk("se_err",       32'(mem_err),   32'h1);
      chk("se_rdata",     mem_rdata,      ERRD);
      chk("se_err_cause", 32'(err_cause), 32'h3);
      chk("se_err_addr",  err_addr,       32'h0300_3000);
      tick();
      mem_valid  = 1'b0;
      pslverr[1] = 1'b0;
      tick();

      // Clear together with a new decode miss captures the new error
      req(32'hBEEF_0000, 32'h0, 4'b0000);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("cc_ready",     32'(mem_ready), 32'h1);
      chk("cc_err_valid", 32'(err_valid), 32'h1);
      chk("cc_err_cause", 32'(err_cause), 32'h1);
      chk("cc_err_addr",  err_addr,       32'hBEEF_0000);
      tick();
      mem_valid = 1'b0;
      tick();

      // Overlap: slaves 0 and 2 both match, slave 0 wins; reset mid-ACCESS
      pready[0] = 1'b0;
      req(32'h0300_2000, 32'h0, 4'b0000);
      tick();
      chk("ov_psel", 32'(psel), 32'h1);
      tick();
      chk("ov_c2_penable", 32'(penable), 32'h1);
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      mem_valid = 1'b0;
      chk("mr_psel",      32'(psel),      32'h0);
      chk("mr_penable",   32'(penable),   32'h0);
      chk("mr_ready",     32'(mem_ready), 32'h0);
      chk("mr_err_valid", 32'(err_valid), 32'h0);
      pready[0] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("mr_no_ready", 32'(mem_ready), 32'h0);
      end

      // Next request after the reset completes normally
      req(32'h0300_3000, 32'h0, 4'b0000);
      tick();
      chk("nx_psel", 32'(psel), 32'h4);
      tick();
      tick();
      chk("nx_ready", 32'(mem_ready), 32'h1);
      chk("nx_err",   32'(mem_err),   32'h0);
      chk("nx_rdata", mem_rdata,      32'hA5A5_0002);
      tick();
      mem_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
